// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, datapath width and the multiply sequencer state type.
package alu_pkg;

   localparam int ALU_XLEN = 32;

   localparam logic [3:0] ALU_OP_ADD = 4'd0;
   localparam logic [3:0] ALU_OP_SUB = 4'd1;
   localparam logic [3:0] ALU_OP_AND = 4'd2;
   localparam logic [3:0] ALU_OP_OR  = 4'd3;
   localparam logic [3:0] ALU_OP_XOR = 4'd4;
   localparam logic [3:0] ALU_OP_NOR = 4'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational 32-bit ALU used by the execute stage and the multiply sequencer.
module alu
   import alu_pkg::*;
(
   input  logic [ALU_XLEN-1:0] a,
   input  logic [ALU_XLEN-1:0] b,
   input  logic [3:0]          alu_op,
   output logic [ALU_XLEN-1:0] result
);

   always_comb begin
      result = '0;
      case (alu_op)
         ALU_OP_ADD: result = a + b;
         ALU_OP_SUB: result = a - b;
         ALU_OP_AND: result = a & b;
         ALU_OP_OR:  result = a | b;
         ALU_OP_XOR: result = a ^ b;
         ALU_OP_NOR: result = ~(a | b);
         default:    result = '0;
      endcase
   end

endmodule

// File: rtl/alu_carry_gen.sv
// Recovers the carry-out of an ADD from operand and sum MSBs, since the ALU exposes no carry.
module alu_carry_gen #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] sum,
   output logic         carry
);

   assign carry = (a[W-1] & b[W-1]) | ((a[W-1] | b[W-1]) & ~sum[W-1]);

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned XLEN x XLEN multiplier borrowing the shared ALU adder, one multiplier bit per cycle.
// state | meaning
// IDLE  | waiting for start, ALU released
// RUN   | XLEN accumulate/shift iterations, ALU owned
// DONE  | one-cycle done pulse, start here reloads back-to-back
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [XLEN-1:0]   multiplicand,
   input  logic [XLEN-1:0]   multiplier,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   output logic [3:0]        alu_op,
   input  logic [XLEN-1:0]   alu_result,
   output logic              busy,
   output logic              done,
   output logic [2*XLEN-1:0] product
);

   if (XLEN != ALU_XLEN) begin : g_bad_xlen
      $error("alu_mul_seq: XLEN must equal the ALU width");
   end

   mul_state_t        state_q, state_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              carry;

   alu_carry_gen #(.W(XLEN)) u_carry_gen (
      .a     (hi_q),
      .b     (mcand_q),
      .sum   (alu_result),
      .carry (carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mcand_d = multiplicand;
               lo_d    = multiplier;
               hi_d    = '0;
               cnt_d   = '0;
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // The shifted-out carry lands in hi's MSB, so the accumulator never loses a bit.
            if (lo_q[0]) begin
               {hi_d, lo_d} = {carry, alu_result, lo_q[XLEN-1:1]};
            end else begin
               {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign alu_a   = busy ? hi_q : '0;
   assign alu_b   = busy ? mcand_q : '0;
   assign alu_op  = ALU_OP_ADD;
   assign product = {hi_q, lo_q};

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq wired to the shared alu; products checked against a 64-bit arithmetic model.
module tb_alu_mul_seq;
   import alu_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        busy;
   logic        done;
   logic [63:0] product;

   int n_checks = 0;
   int n_errors = 0;

   alu_mul_seq u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .alu_op (alu_op),
      .result (alu_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b);
      return {32'd0, a} * {32'd0, b};
   endfunction

   // Call at a negedge; start is sampled at the following posedge.
   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      start        = 1'b1;
      multiplicand = a;
      multiplier   = b;
   endtask

   // Follows one operation from the launch negedge until the done negedge.
   // inject: fire ignored start pulses at RUN cycles 5 and 20; rst_at>0: async reset at that cycle.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, input int rst_at);
      int cycles;
      int busy_cnt;
      bit got_done;
      logic [63:0] exp;
      exp      = model_mul(a, b);
      cycles   = 0;
      busy_cnt = 0;
      got_done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         cycles = i + 1;
         start  = 1'b0;
         if (inject && (cycles == 5 || cycles == 20)) begin
            start        = 1'b1;
            multiplicand = $urandom;
            multiplier   = $urandom;
         end
         if (rst_at > 0 && cycles == rst_at) begin
            #2 rst = 1'b1;
            #1;
            check({tag, "_rst_busy"}, 64'(busy), 64'd0);
            check({tag, "_rst_done"}, 64'(done), 64'd0);
            check({tag, "_rst_product"}, product, 64'd0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check({tag, "_post_rst_done"}, 64'(done), 64'd0);
            check({tag, "_post_rst_busy"}, 64'(busy), 64'd0);
            return;
         end
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (busy) busy_cnt++;
         if (cycles == 1) begin
            check({tag, "_alu_b_run"}, 64'(alu_b), 64'(a));
            check({tag, "_alu_op_run"}, 64'(alu_op), 64'(ALU_OP_ADD));
         end
      end
      check({tag, "_done_seen"}, 64'(got_done), 64'd1);
      check({tag, "_latency"}, 64'(cycles), 64'd33);
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
      check({tag, "_product"}, product, exp);
      check({tag, "_alu_a_done"}, 64'(alu_a), 64'd0);
   endtask

   // One negedge after done with start low: back in IDLE, product held.
   task automatic check_idle(input string tag, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      check({tag, "_idle_done"}, 64'(done), 64'd0);
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
      check({tag, "_idle_hold"}, product, model_mul(a, b));
      check({tag, "_idle_alu_b"}, 64'(alu_b), 64'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      rst          = 1'b1;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_product", product, 64'd0);
      check("reset_alu_a", 64'(alu_a), 64'd0);
      check("reset_alu_b", 64'(alu_b), 64'd0);
      check("reset_alu_op", 64'(alu_op), 64'(ALU_OP_ADD));
      rst = 1'b0;
      @(negedge clk);

      launch(32'd3, 32'd5);
      run_op("t1_3x5", 32'd3, 32'd5, 1'b0, 0);
      check("t1_value", product, 64'h0000_0000_0000_000F);
      check_idle("t1", 32'd3, 32'd5);

      launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("t2_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
      check("t2_value", product, 64'hFFFF_FFFE_0000_0001);
      check_idle("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      launch(32'd0, 32'h1234_5678);
      run_op("t3_zero", 32'd0, 32'h1234_5678, 1'b0, 0);
      check_idle("t3", 32'd0, 32'h1234_5678);

      launch(32'hDEAD_BEEF, 32'h0BAD_F00D);
      run_op("t4_ignore", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 0);
      check_idle("t4", 32'hDEAD_BEEF, 32'h0BAD_F00D);

      launch(32'h5555_AAAA, 32'h1357_9BDF);
      run_op("t5_rst", 32'h5555_AAAA, 32'h1357_9BDF, 1'b0, 10);
      launch(32'd7, 32'd6);
      run_op("t5_after", 32'd7, 32'd6, 1'b0, 0);
      check("t5_value", product, 64'd42);
      check_idle("t5", 32'd7, 32'd6);

      launch(32'h0000_FFFF, 32'h8000_0001);
      run_op("t6_first", 32'h0000_FFFF, 32'h8000_0001, 1'b0, 0);
      launch(32'h0001_0000, 32'h0001_0000);
      run_op("t6_b2b", 32'h0001_0000, 32'h0001_0000, 1'b0, 0);
      check("t6_value", product, 64'h0000_0001_0000_0000);
      check_idle("t6", 32'h0001_0000, 32'h0001_0000);

      for (int k = 0; k < 12; k++) begin
         ra = $urandom;
         rb = $urandom;
         if (k == 0) ra = 32'h8000_0000;
         if (k == 1) rb = 32'd1;
         launch(ra, rb);
         run_op("rand", ra, rb, 1'b0, 0);
         if (k[0]) check_idle("rand", ra, rb);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
